// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB encodings and the master-port FSM state type.
package ahb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [1:0] {
      OKAY  = 2'd0,
      ERROR = 2'd1,
      RETRY = 2'd2,
      SPLIT = 2'd3
   } hresp_t;

   localparam logic [2:0] HBURST_INCR = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;

   // Master FSM: IDLE waits for a command, REQ asks the arbiter, ADDR issues
   // beats, LAST drains the final data phase, RESP rides out a two-cycle
   // non-OKAY response.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_ADDR = 3'd2,
      ST_LAST = 3'd3,
      ST_RESP = 3'd4
   } mst_state_e;

endpackage

// File: rtl/ahb_addr_gen.sv
// ahb_addr_gen: next-unissued address / beat counter. Remembers the beat
// currently in its data phase so a RETRY/SPLIT can rewind to it.
module ahb_addr_gen
   import ahb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int BW     = 5
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              load_i,
   input  logic              inc_i,
   input  logic              rewind_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [BW-1:0]     beats_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [BW-1:0]     beats_o
);

   logic [ADDR_W-1:0] addr_q, addr_d, dp_addr_q, dp_addr_d;
   logic [BW-1:0]     beats_q, beats_d, dp_beats_q, dp_beats_d;

   // Load a new command, step past an accepted beat, or rewind to the failed one.
   always_comb begin
      addr_d     = addr_q;
      beats_d    = beats_q;
      dp_addr_d  = dp_addr_q;
      dp_beats_d = dp_beats_q;
      if (load_i) begin
         addr_d  = addr_i;
         beats_d = beats_i;
      end else if (rewind_i) begin
         addr_d  = dp_addr_q;
         beats_d = dp_beats_q;
      end else if (inc_i) begin
         dp_addr_d  = addr_q;
         dp_beats_d = beats_q;
         addr_d     = addr_q + ADDR_W'(4);
         beats_d    = beats_q - BW'(1);
      end
   end

   // Counter state.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_q     <= '0;
         beats_q    <= '0;
         dp_addr_q  <= '0;
         dp_beats_q <= '0;
      end else begin
         addr_q     <= addr_d;
         beats_q    <= beats_d;
         dp_addr_q  <= dp_addr_d;
         dp_beats_q <= dp_beats_d;
      end
   end

   assign addr_o  = addr_q;
   assign beats_o = beats_q;

endmodule

// File: rtl/ahb_master_port.sv
// ahb_master_port: turns one local burst command into an AHB INCR burst,
// handling wait states, grant loss and OKAY/ERROR/RETRY/SPLIT responses.
// Optional: define AHB_MASTER_LOCK_EN to add cmd_lock and drive HLOCK.
module ahb_master_port
   import ahb_pkg::*;
#(
   parameter int  ADDR_W    = 32,
   parameter int  DATA_W    = 32,
   parameter int  MAX_BEATS = 16,
   localparam int BW        = $clog2(MAX_BEATS + 1)
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [BW-1:0]     cmd_beats,
`ifdef AHB_MASTER_LOCK_EN
   input  logic              cmd_lock,
`endif
   input  logic [DATA_W-1:0] wdata,
   output logic              wdata_ack,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              done,
   output logic              err,
   output logic              HBUSREQ,
   output logic              HLOCK,
   input  logic              HGRANT,
   input  logic              HREADY,
   input  logic [1:0]        HRESP,
   input  logic [DATA_W-1:0] HRDATA,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic [DATA_W-1:0] HWDATA
);

   mst_state_e        state_q, state_d;
   hresp_t            resp_q;
   logic              owner_q, first_q, first_d, dp_vld_q, write_q;
   logic              ack_q, rdv_q, done_q, done_d, err_q, err_d;
   logic [DATA_W-1:0] rdata_q;
   logic              load, inc, rewind;
   logic              active, accept, dp_done_ok, resp_start;
   logic [ADDR_W-1:0] addr;
   logic [BW-1:0]     beats_left, beats_ld;

   // A zero-beat command still moves one word.
   assign beats_ld = (cmd_beats == '0) ? BW'(1) : cmd_beats;

   ahb_addr_gen #(.ADDR_W(ADDR_W), .BW(BW)) u_addr_gen (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .load_i   (load),
      .inc_i    (inc),
      .rewind_i (rewind),
      .addr_i   (cmd_addr),
      .beats_i  (beats_ld),
      .addr_o   (addr),
      .beats_o  (beats_left)
   );

   assign active     = (state_q == ST_ADDR) && owner_q;
   assign accept     = active && HREADY;
   assign dp_done_ok = dp_vld_q && HREADY && (HRESP == OKAY);
   // First cycle of a two-cycle non-OKAY response on our data phase.
   assign resp_start = dp_vld_q && !HREADY && (HRESP != OKAY);

   // Burst sequencing; a pending response beats every other transition.
   always_comb begin
      state_d = state_q;
      first_d = first_q;
      load    = 1'b0;
      inc     = 1'b0;
      rewind  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: if (cmd_valid) begin
            load    = 1'b1;
            state_d = ST_REQ;
         end
         ST_REQ: begin
            if (resp_start) state_d = ST_RESP;
            else if (HGRANT && HREADY) begin
               state_d = ST_ADDR;
               first_d = 1'b1;
            end
         end
         ST_ADDR: begin
            if (resp_start) state_d = ST_RESP;
            else if (accept) begin
               inc     = 1'b1;
               first_d = 1'b0;
               if (beats_left == BW'(1)) state_d = ST_LAST;
               else if (!HGRANT)         state_d = ST_REQ;
            end
         end
         ST_LAST: begin
            if (resp_start) state_d = ST_RESP;
            else if (dp_done_ok) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         ST_RESP: if (HREADY) begin
            if (resp_q == ERROR) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else begin
               rewind  = 1'b1;
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM, bus-ownership tracking, data-phase tracking and user-side pulses.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= ST_IDLE;
         resp_q   <= OKAY;
         owner_q  <= 1'b0;
         first_q  <= 1'b0;
         dp_vld_q <= 1'b0;
         write_q  <= 1'b0;
         ack_q    <= 1'b0;
         rdv_q    <= 1'b0;
         rdata_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
         if (HREADY) owner_q  <= HGRANT;
         if (HREADY) dp_vld_q <= accept;
         if (load) write_q <= cmd_write;
         if (resp_start && state_q != ST_RESP) resp_q <= hresp_t'(HRESP);
         ack_q <= dp_done_ok && write_q;
         rdv_q <= dp_done_ok && !write_q;
         if (dp_done_ok && !write_q) rdata_q <= HRDATA;
         done_q <= done_d;
         err_q  <= err_d;
      end
   end

`ifdef AHB_MASTER_LOCK_EN
   logic lock_q;
   // Lock choice is captured with the command and held for the whole burst.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)  lock_q <= 1'b0;
      else if (load) lock_q <= cmd_lock;
   end
   assign HLOCK = lock_q && (state_q != ST_IDLE);
`else
   assign HLOCK = 1'b0;
`endif

   assign cmd_ready   = (state_q == ST_IDLE);
   assign HBUSREQ     = (state_q == ST_REQ) || ((state_q == ST_ADDR) && (beats_left > BW'(1)));
   assign HTRANS      = active ? (first_q ? NONSEQ : SEQ) : IDLE;
   assign HADDR       = active ? addr : '0;
   assign HWRITE      = active && write_q;
   assign HSIZE       = HSIZE_WORD;
   assign HBURST      = HBURST_INCR;
   assign HWDATA      = (dp_vld_q && write_q) ? wdata : '0;
   assign wdata_ack   = ack_q;
   assign rdata_valid = rdv_q;
   assign rdata       = rdata_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_ahb_master_port.sv
// Directed bench for ahb_master_port: per-cycle HREADY/HGRANT/HRESP patterns,
// trace capture, and hand-computed expectations per scenario.
module tb_ahb_master_port;

   localparam logic [1:0] T_IDLE = 2'b00, T_NSEQ = 2'b10, T_SEQ = 2'b11;

   logic        HCLK, HRESETn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, wdata, rdata, HRDATA, HADDR, HWDATA;
   logic [4:0]  cmd_beats;
   logic        wdata_ack, rdata_valid, done, err;
   logic        HBUSREQ, HLOCK, HGRANT, HREADY, HWRITE;
   logic [1:0]  HRESP, HTRANS;
   logic [2:0]  HSIZE, HBURST;
`ifdef AHB_MASTER_LOCK_EN
   logic        cmd_lock;
`endif

   ahb_master_port dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
`ifdef AHB_MASTER_LOCK_EN
      .cmd_lock(cmd_lock),
`endif
      .wdata(wdata), .wdata_ack(wdata_ack), .rdata(rdata), .rdata_valid(rdata_valid),
      .done(done), .err(err), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HGRANT(HGRANT),
      .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   int n_vec = 0, n_miss = 0;

   logic        pat_hready[64];
   logic        pat_hgrant[64];
   logic [1:0]  pat_hresp[64];
   logic [1:0]  tr_htrans[64];
   logic [31:0] tr_haddr[64];
   logic [31:0] tr_hwdata[64];
   logic        tr_busreq[64];
   logic [1:0]  acc_trans[16];
   logic [31:0] acc_addr[16];
   logic [31:0] rd_val[16];
   int          n_acc, n_ack, n_rdv, n_done, n_errp, n_lock, done_cyc, err_cyc;
   logic        err_busreq, err_ready;

   task automatic clear_pat();
      for (int i = 0; i < 64; i++) begin
         pat_hready[i] = 1'b1;
         pat_hgrant[i] = 1'b1;
         pat_hresp[i]  = 2'd0;
      end
   endtask

   // Issue one command, then play the patterns cycle by cycle (cycle 0 is the
   // first cycle after acceptance) until two cycles past done/err or budget.
   task automatic run_burst(input logic wr, input logic [31:0] a, input logic [4:0] nb);
      int tail;
      n_acc = 0; n_ack = 0; n_rdv = 0; n_done = 0; n_errp = 0; n_lock = 0;
      done_cyc = -1; err_cyc = -1; err_busreq = 1'bx; err_ready = 1'bx;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_beats = nb;
      @(posedge HCLK); #1;
      cmd_valid = 1'b0;
      tail = -1;
      for (int c = 0; c < 60; c++) begin
         HREADY = pat_hready[c]; HGRANT = pat_hgrant[c]; HRESP = pat_hresp[c];
         HRDATA = 32'hD000_0000 + 32'(c);
         #1;
         tr_htrans[c] = HTRANS; tr_haddr[c] = HADDR;
         tr_hwdata[c] = HWDATA; tr_busreq[c] = HBUSREQ;
         if (HLOCK !== 1'b0) n_lock++;
         if (HTRANS != T_IDLE && HREADY && n_acc < 16) begin
            acc_trans[n_acc] = HTRANS; acc_addr[n_acc] = HADDR; n_acc++;
         end
         if (wdata_ack) n_ack++;
         if (rdata_valid && n_rdv < 16) begin rd_val[n_rdv] = rdata; n_rdv++; end
         if (done) begin n_done++; done_cyc = c; end
         if (err) begin n_errp++; err_cyc = c; err_busreq = HBUSREQ; err_ready = cmd_ready; end
         if (tail < 0 && (done || err)) tail = 2;
         else if (tail > 0) begin
            tail--;
            if (tail == 0) break;
         end
         @(posedge HCLK); #1;
      end
      HREADY = 1'b1; HGRANT = 1'b1; HRESP = 2'd0;
   endtask

   task automatic test_reset();
      #12;
      n_vec++; if (HTRANS !== T_IDLE) begin n_miss++; $display("FAIL rst_htrans got %h exp %h", HTRANS, T_IDLE); end
      n_vec++; if (HADDR !== 32'h0) begin n_miss++; $display("FAIL rst_haddr got %h exp 0", HADDR); end
      n_vec++; if (HBUSREQ !== 1'b0 || HLOCK !== 1'b0 || HWRITE !== 1'b0) begin n_miss++; $display("FAIL rst_ctrl got busreq=%b lock=%b write=%b exp 0", HBUSREQ, HLOCK, HWRITE); end
      n_vec++; if (cmd_ready !== 1'b1) begin n_miss++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
      n_vec++; if (HWDATA !== 32'h0 || rdata !== 32'h0) begin n_miss++; $display("FAIL rst_data got hwdata=%h rdata=%h exp 0", HWDATA, rdata); end
      n_vec++; if ({wdata_ack, rdata_valid, done, err} !== 4'b0) begin n_miss++; $display("FAIL rst_pulses got %b exp 0000", {wdata_ack, rdata_valid, done, err}); end
      n_vec++; if (HSIZE !== 3'b010 || HBURST !== 3'b001) begin n_miss++; $display("FAIL rst_size_burst got %b/%b exp 010/001", HSIZE, HBURST); end
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      @(posedge HCLK); #1;
   endtask

   task automatic test_write_burst();
      clear_pat(); wdata = 32'hCAFE_0001;
      run_burst(1'b1, 32'h100, 5'd4);
      n_vec++; if (n_acc !== 4) begin n_miss++; $display("FAIL wr_nacc got %0d exp 4", n_acc); end
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (acc_trans[i] !== ((i == 0) ? T_NSEQ : T_SEQ) || acc_addr[i] !== 32'h100 + 32'(4 * i)) begin
            n_miss++; $display("FAIL wr_beat%0d got %h@%h exp %h@%h", i, acc_trans[i], acc_addr[i], (i == 0) ? T_NSEQ : T_SEQ, 32'h100 + 32'(4 * i));
         end
      end
      n_vec++; if (tr_htrans[0] !== T_IDLE || tr_busreq[0] !== 1'b1) begin n_miss++; $display("FAIL wr_req_cycle got %h/%b exp 0/1", tr_htrans[0], tr_busreq[0]); end
      n_vec++; if (tr_busreq[4] !== 1'b0) begin n_miss++; $display("FAIL wr_busreq_drop got %b exp 0", tr_busreq[4]); end
      n_vec++; if (tr_hwdata[2] !== 32'hCAFE_0001 || tr_hwdata[1] !== 32'h0) begin n_miss++; $display("FAIL wr_hwdata got %h/%h exp cafe0001/0", tr_hwdata[2], tr_hwdata[1]); end
      n_vec++; if (n_ack !== 4) begin n_miss++; $display("FAIL wr_acks got %0d exp 4", n_ack); end
      n_vec++; if (n_done !== 1 || done_cyc !== 6) begin n_miss++; $display("FAIL wr_done got n=%0d cyc=%0d exp 1/6", n_done, done_cyc); end
      n_vec++; if (n_lock !== 0) begin n_miss++; $display("FAIL wr_hlock got %0d cycles exp 0", n_lock); end
   endtask

   task automatic test_read_wait();
      clear_pat();
      pat_hready[2] = 1'b0; pat_hready[3] = 1'b0;
      run_burst(1'b0, 32'h200, 5'd2);
      n_vec++; if (n_acc !== 2 || acc_addr[0] !== 32'h200 || acc_trans[1] !== T_SEQ || acc_addr[1] !== 32'h204) begin
         n_miss++; $display("FAIL rd_beats got n=%0d %h %h@%h exp 2 200 3@204", n_acc, acc_addr[0], acc_trans[1], acc_addr[1]); end
      n_vec++; if (tr_htrans[2] !== T_SEQ || tr_htrans[3] !== T_SEQ || tr_haddr[3] !== 32'h204) begin
         n_miss++; $display("FAIL rd_hold got %h %h @%h exp 3 3 @204", tr_htrans[2], tr_htrans[3], tr_haddr[3]); end
      n_vec++; if (n_rdv !== 2 || rd_val[0] !== 32'hD000_0004 || rd_val[1] !== 32'hD000_0005) begin
         n_miss++; $display("FAIL rd_data got n=%0d %h %h exp 2 d0000004 d0000005", n_rdv, rd_val[0], rd_val[1]); end
      n_vec++; if (n_done !== 1 || done_cyc !== 6 || n_ack !== 0) begin n_miss++; $display("FAIL rd_done got n=%0d cyc=%0d acks=%0d exp 1/6/0", n_done, done_cyc, n_ack); end
   endtask

   task automatic test_grant_loss();
      clear_pat(); wdata = 32'h5A5A_0000;
      pat_hgrant[4] = 1'b0; pat_hgrant[5] = 1'b0; pat_hgrant[6] = 1'b0;
      run_burst(1'b1, 32'h100, 5'd8);
      n_vec++; if (tr_htrans[5] !== T_IDLE || tr_htrans[6] !== T_IDLE || tr_htrans[7] !== T_IDLE) begin
         n_miss++; $display("FAIL gl_idle got %h %h %h exp 0 0 0", tr_htrans[5], tr_htrans[6], tr_htrans[7]); end
      n_vec++; if (tr_busreq[5] !== 1'b1 || tr_hwdata[5] !== 32'h5A5A_0000) begin n_miss++; $display("FAIL gl_req_data got %b/%h exp 1/5a5a0000", tr_busreq[5], tr_hwdata[5]); end
      n_vec++; if (n_acc !== 8 || acc_trans[4] !== T_NSEQ || acc_addr[4] !== 32'h110 || acc_addr[7] !== 32'h11C) begin
         n_miss++; $display("FAIL gl_regrant got n=%0d %h@%h last@%h exp 8 2@110 11c", n_acc, acc_trans[4], acc_addr[4], acc_addr[7]); end
      n_vec++; if (n_ack !== 8 || n_done !== 1 || done_cyc !== 13) begin n_miss++; $display("FAIL gl_done got acks=%0d n=%0d cyc=%0d exp 8/1/13", n_ack, n_done, done_cyc); end
   endtask

   task automatic test_retry();
      clear_pat(); wdata = 32'h0BAD_F00D;
      pat_hready[4] = 1'b0; pat_hresp[4] = 2'd2; pat_hresp[5] = 2'd2;
      run_burst(1'b1, 32'h300, 5'd4);
      n_vec++; if (tr_htrans[5] !== T_IDLE || tr_htrans[6] !== T_IDLE || tr_busreq[6] !== 1'b1) begin
         n_miss++; $display("FAIL rt_idle got %h %h req=%b exp 0 0 1", tr_htrans[5], tr_htrans[6], tr_busreq[6]); end
      n_vec++; if (n_acc !== 5 || acc_trans[3] !== T_NSEQ || acc_addr[3] !== 32'h308 || acc_addr[4] !== 32'h30C) begin
         n_miss++; $display("FAIL rt_rewind got n=%0d %h@%h next@%h exp 5 2@308 30c", n_acc, acc_trans[3], acc_addr[3], acc_addr[4]); end
      n_vec++; if (n_ack !== 4 || n_done !== 1 || done_cyc !== 10 || n_errp !== 0) begin
         n_miss++; $display("FAIL rt_done got acks=%0d n=%0d cyc=%0d err=%0d exp 4/1/10/0", n_ack, n_done, done_cyc, n_errp); end
   endtask

   task automatic test_error();
      clear_pat(); wdata = 32'hEEEE_0001;
      pat_hready[3] = 1'b0; pat_hresp[3] = 2'd1; pat_hresp[4] = 2'd1;
      run_burst(1'b1, 32'h400, 5'd4);
      n_vec++; if (n_errp !== 1 || err_cyc !== 5 || n_done !== 0) begin n_miss++; $display("FAIL er_pulse got err=%0d cyc=%0d done=%0d exp 1/5/0", n_errp, err_cyc, n_done); end
      n_vec++; if (err_busreq !== 1'b0 || err_ready !== 1'b1) begin n_miss++; $display("FAIL er_idle got busreq=%b ready=%b exp 0/1", err_busreq, err_ready); end
      n_vec++; if (n_ack !== 1 || n_acc !== 2 || tr_htrans[4] !== T_IDLE) begin n_miss++; $display("FAIL er_beats got acks=%0d acc=%0d htrans=%h exp 1/2/0", n_ack, n_acc, tr_htrans[4]); end
   endtask

   task automatic test_zero_beats();
      clear_pat();
      run_burst(1'b0, 32'h700, 5'd0);
      n_vec++; if (n_acc !== 1 || acc_trans[0] !== T_NSEQ || acc_addr[0] !== 32'h700) begin
         n_miss++; $display("FAIL zb_beat got n=%0d %h@%h exp 1 2@700", n_acc, acc_trans[0], acc_addr[0]); end
      n_vec++; if (n_rdv !== 1 || rd_val[0] !== 32'hD000_0002 || n_done !== 1 || done_cyc !== 3) begin
         n_miss++; $display("FAIL zb_done got rdv=%0d %h n=%0d cyc=%0d exp 1 d0000002 1 3", n_rdv, rd_val[0], n_done, done_cyc); end
   endtask

   task automatic test_async_reset();
      clear_pat(); wdata = 32'h1234_5678;
      HREADY = 1'b1; HGRANT = 1'b1; HRESP = 2'd0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h600; cmd_beats = 5'd4;
      @(posedge HCLK); #1; cmd_valid = 1'b0;
      @(posedge HCLK); #1;
      @(posedge HCLK); #1;
      n_vec++; if (HTRANS !== T_SEQ || HADDR !== 32'h604) begin n_miss++; $display("FAIL ar_midburst got %h@%h exp 3@604", HTRANS, HADDR); end
      #2 HRESETn = 1'b0;
      #1;
      n_vec++; if (HTRANS !== T_IDLE || HADDR !== 32'h0 || HBUSREQ !== 1'b0 || HWDATA !== 32'h0) begin
         n_miss++; $display("FAIL ar_outputs got %h@%h req=%b wd=%h exp 0@0 0 0", HTRANS, HADDR, HBUSREQ, HWDATA); end
      n_vec++; if (cmd_ready !== 1'b1 || {wdata_ack, done, err} !== 3'b0) begin n_miss++; $display("FAIL ar_ctrl got ready=%b pulses=%b exp 1 000", cmd_ready, {wdata_ack, done, err}); end
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      @(posedge HCLK); #1;
      clear_pat();
      run_burst(1'b0, 32'h500, 5'd2);
      n_vec++; if (n_acc !== 2 || acc_trans[0] !== T_NSEQ || acc_addr[0] !== 32'h500 || acc_addr[1] !== 32'h504) begin
         n_miss++; $display("FAIL ar_restart got n=%0d %h@%h %h exp 2 2@500 504", n_acc, acc_trans[0], acc_addr[0], acc_addr[1]); end
      n_vec++; if (n_rdv !== 2 || rd_val[0] !== 32'hD000_0002 || rd_val[1] !== 32'hD000_0003 || n_done !== 1 || done_cyc !== 4 || n_ack !== 0) begin
         n_miss++; $display("FAIL ar_done got rdv=%0d %h %h n=%0d cyc=%0d acks=%0d exp 2 d0000002 d0000003 1 4 0", n_rdv, rd_val[0], rd_val[1], n_done, done_cyc, n_ack); end
   endtask

   initial begin
      HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_beats = '0;
      wdata = '0; HGRANT = 1'b1; HREADY = 1'b1; HRESP = 2'd0; HRDATA = '0;
`ifdef AHB_MASTER_LOCK_EN
      cmd_lock = 1'b0;
`endif
      test_reset();
      test_write_burst();
      test_read_wait();
      test_grant_loss();
      test_retry();
      test_error();
      test_zero_beats();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
